// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: micro-rotation angle table, gain and FSM states.
// Used by both the rotation (angle -> X/Y) and vectoring paths.
package cordic_pkg;

    localparam int K_Q15 = 53961;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_e;

    // atan(2^-i) in binary-angle units, exact table for DSIZE=16 and rescaled otherwise;
    // deep iterations past the table fall back to 2^(dsize-i)/(2*pi), rounded.
    function automatic longint atan_scaled(input int i, input int dsize);
        longint v;
        v = 0;
        case (i)
            0:  v = 8192;
            1:  v = 4836;
            2:  v = 2555;
            3:  v = 1297;
            4:  v = 651;
            5:  v = 326;
            6:  v = 163;
            7:  v = 81;
            8:  v = 41;
            9:  v = 20;
            10: v = 10;
            11: v = 5;
            12: v = 3;
            13: v = 1;
            default: v = -1;
        endcase
        if (v >= 0) begin
            if (dsize >= 16) v = v << (dsize - 16);
            else             v = v >> (16 - dsize);
        end else begin
            v = ((longint'(1) << (dsize - i + 17)) / longint'(411775) + 1) >>> 1;
        end
        return v;
    endfunction

endpackage

// File: rtl/angle_to_x_y_if.sv
// Request/result handshake bundle for the angle-to-X/Y converter.
interface angle_to_x_y_if #(
    parameter int DSIZE = 16,
    parameter int ITER  = 14
);
    logic             in_valid;
    logic             in_ready;
    logic [DSIZE-1:0] angle;
    logic [DSIZE-1:0] mag;
    logic             out_valid;
    logic             out_ready;
    logic [DSIZE-1:0] X_rel;
    logic [DSIZE-1:0] Y_rel;
    logic [ITER-1:0]  dir_rel;

    modport master (
        output in_valid, angle, mag, out_ready,
        input  in_ready, out_valid, X_rel, Y_rel, dir_rel
    );

    modport slave (
        input  in_valid, angle, mag, out_ready,
        output in_ready, out_valid, X_rel, Y_rel, dir_rel
    );
endinterface

// File: rtl/cordic_rot_stage.sv
// One combinational CORDIC micro-rotation with run-time shift amount and direction.
// dir_i=1 rotates clockwise in z (z decreases), matching the vectoring cmp_rel sense.
module cordic_rot_stage #(
    parameter int XW = 18,
    parameter int ZW = 17,
    parameter int SW = 4
) (
    input  logic signed [XW-1:0] x_i,
    input  logic signed [XW-1:0] y_i,
    input  logic signed [ZW-1:0] z_i,
    input  logic        [SW-1:0] shift_i,
    input  logic                 dir_i,
    input  logic        [ZW-1:0] atan_i,
    output logic signed [XW-1:0] x_o,
    output logic signed [XW-1:0] y_o,
    output logic signed [ZW-1:0] z_o
);
    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;
    logic signed [ZW-1:0] atan_s;

    always_comb begin
        x_sh   = x_i >>> shift_i;
        y_sh   = y_i >>> shift_i;
        atan_s = $signed(atan_i);
        if (dir_i) begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_s;
        end else begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_s;
        end
    end
endmodule

// File: rtl/angle_to_x_y.sv
// Iterative rotation-mode CORDIC: binary angle + magnitude -> K-scaled X/Y.
// One shared micro-rotation runs ITER times; results and direction bits are registered.
module angle_to_x_y
    import cordic_pkg::*;
#(
    parameter int DSIZE = 16,
    parameter int ITER  = 14
) (
    input logic          clock,
    input logic          rst_n,
    angle_to_x_y_if.slave bus
);
    localparam int XW = DSIZE + 2;
    localparam int ZW = DSIZE + 1;
    localparam int CW = $clog2(ITER);
    localparam logic signed [DSIZE-1:0] QTR = DSIZE'(1 << (DSIZE - 2));

    state_e               state_q, state_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0] z_q, z_d;
    logic [CW-1:0]        iter_q, iter_d;
    logic [ITER-1:0]      dir_q, dir_d;
    logic [DSIZE-1:0]     x_rel_q, x_rel_d, y_rel_q, y_rel_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;

    logic signed [XW-1:0] x_rot, y_rot, mag_x;
    logic signed [ZW-1:0] z_rot;
    logic                 d_rot;
    logic signed [DSIZE-1:0] angle_s;
    logic [DSIZE-1:0]     angle_wrap;
    logic                 in_range;
    logic [ZW-1:0]        atan_tbl [2**CW];

    for (genvar k = 0; k < 2**CW; k++) begin : g_atan
        localparam longint AV = (k < ITER) ? atan_scaled(k, DSIZE) : 64'd0;
        assign atan_tbl[k] = AV[ZW-1:0];
    end

    assign d_rot = ~z_q[ZW-1];

    cordic_rot_stage #(.XW(XW), .ZW(ZW), .SW(CW)) u_stage (
        .x_i     (x_q),
        .y_i     (y_q),
        .z_i     (z_q),
        .shift_i (iter_q),
        .dir_i   (d_rot),
        .atan_i  (atan_tbl[iter_q]),
        .x_o     (x_rot),
        .y_o     (y_rot),
        .z_o     (z_rot)
    );

    always_comb begin
        angle_s     = $signed(bus.angle);
        in_range    = (angle_s >= -QTR) && (angle_s <= QTR);
        // Subtracting a half turn modulo 2^DSIZE is just an MSB flip.
        angle_wrap  = {~bus.angle[DSIZE-1], bus.angle[DSIZE-2:0]};
        mag_x       = $signed({{2{bus.mag[DSIZE-1]}}, bus.mag});

        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        iter_d      = iter_q;
        dir_d       = dir_q;
        x_rel_d     = x_rel_q;
        y_rel_d     = y_rel_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d        = in_range ? mag_x : -mag_x;
                    y_d        = '0;
                    z_d        = in_range ? $signed({bus.angle[DSIZE-1], bus.angle})
                                          : $signed({angle_wrap[DSIZE-1], angle_wrap});
                    iter_d     = '0;
                    in_ready_d = 1'b0;
                    state_d    = ROT;
                end
            end
            ROT: begin
                x_d           = x_rot;
                y_d           = y_rot;
                z_d           = z_rot;
                dir_d[iter_q] = d_rot;
                if (iter_q == CW'(ITER - 1)) begin
                    x_rel_d     = x_rot[DSIZE-1:0];
                    y_rel_d     = y_rot[DSIZE-1:0];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    iter_d = iter_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            iter_q      <= '0;
            dir_q       <= '0;
            x_rel_q     <= '0;
            y_rel_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            iter_q      <= iter_d;
            dir_q       <= dir_d;
            x_rel_q     <= x_rel_d;
            y_rel_q     <= y_rel_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.X_rel     = x_rel_q;
    assign bus.Y_rel     = y_rel_q;
    assign bus.dir_rel   = dir_q;
endmodule
